fft_mem_ctrl: RTL and testbench
===============================

Name: fft_mem_ctrl

Overview:
- Initiator-side controller for the FFT dual-port working RAM. It issues the addresses, write enables and write data on both RAM ports, and drives an external butterfly datapath.
- Runs an in-place radix-2 DIT FFT over all stages, sequencing read -> butterfly -> write-back for every butterfly. Pulses done when the transform is complete.
- Sits between the top-level sequencer (start/done) and the dual RAM + butterfly unit.

Parameters:
- width, 32, RAM word width (complex sample, packed).
- size, 512, number of points; must be a power of 2 and >= 4.
- addr_size, 9, log2(size); RAM address width and number of stages.
- bf_lat, 2, butterfly latency in cycles, >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transform; ignored while busy.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the last write-back has been issued.
- wr_en_0, wr_en_1  out  1  RAM port write enables.
- addr_0, addr_1  out  addr_size  RAM port addresses.
- data_0_in, data_1_in  out  width  RAM write data (to the RAM's data inputs).
- data_0_out, data_1_out  in  width  RAM read data, valid 1 cycle after the address.
- bf_in_valid  out  1  butterfly operands valid.
- bf_a, bf_b  out  width  butterfly operands (a from port 0, b from port 1).
- bf_tw_addr  out  addr_size-1  twiddle index for the current butterfly.
- bf_y0, bf_y1  in  width  butterfly results, valid bf_lat cycles after bf_in_valid.

Behaviour:
- Reset values: busy=0, done=0, wr_en_0/1=0, addr_0/1=0, bf_in_valid=0, bf_tw_addr=0. Internal stage and butterfly counters are 0; state is IDLE.
- States: IDLE, RD, WAIT, BF, WR, FIN. The BREV_* states exist only with the optional feature.
- IDLE: on start=1, load stage s=0 and butterfly index k=0, go to RD (or BREV_RD with the feature).
- Address generation for stage s and butterfly k (0..size/2-1):
  - span = 2^s; pos = k mod span; grp = k >> s.
  - addr_0 = grp*2*span + pos; addr_1 = addr_0 + span.
  - bf_tw_addr = pos << (addr_size-1-s).
- addr_0/addr_1 are registered and held constant from RD through WR of the same butterfly.
- RD: 1 cycle, addresses presented, wr_en=0.
- WAIT: 1 cycle; bf_a=data_0_out, bf_b=data_1_out, bf_in_valid=1.
- BF: bf_lat-1 cycles. Skipped when bf_lat=1.
- WR: 1 cycle; wr_en_0=wr_en_1=1, data_0_in=bf_y0, data_1_in=bf_y1 (pass-through).
- After WR:
  - If k < size/2-1: k+1, go to RD.
  - Else if s < addr_size-1: s+1, k=0, go to RD.
  - Else go to FIN.
- Cycles per butterfly: bf_lat+2. The read of the next butterfly follows the write by at least one cycle, so there are no read/write collisions.
- FIN: done=1 for exactly one cycle, busy falls in the same cycle, return to IDLE.
- Total cycles from start to done pulse: 1 + (size/2)*addr_size*(bf_lat+2).
- wr_en never asserts outside WR (or BREV_WR). Both ports never address the same word in one cycle.
- Reset mid-operation: immediately returns to IDLE with all outputs at reset values. No further writes are issued; RAM contents are undefined.
- start during busy: ignored. start in the same cycle as done: ignored; the next transform needs a new start after IDLE.

Optional Feature:
- Macro FFT_BITREV_EN.
- Defined: before stage 0, an input bit-reversal pass runs.
  - For i = 0..size-1 with rev(i) > i: BREV_RD (addr_0=i, addr_1=rev(i)), BREV_WAIT, BREV_WR (data_0_in=data_1_out, data_1_in=data_0_out, both wr_en=1).
  - Pairs with rev(i) <= i are skipped with zero cycles.
  - Adds 3 cycles per swapped pair, then enters RD.
- Undefined: no BREV states exist; the RAM must already hold bit-reversed input.

Test Plan:
- size=8, addr_size=3, bf_lat=2, identity butterfly (y0=a, y1=b), RAM mem[i]=i, pulse start -> done at exactly 49 cycles after start. Stage 0 address pairs (0,1),(2,3),(4,5),(6,7); stage 2 pairs (0,4),(1,5),(2,6),(3,7). RAM unchanged.
- Same setup, check bf_tw_addr -> stage 0 all 0; stage 1 sequence 0,2,0,2; stage 2 sequence 0,1,2,3.
- Butterfly y0=a+b, y1=a-b (real 16-bit), input impulse mem[0]=1 -> all 8 words equal 1 at done.
- Assert rst_n=0 mid stage 1 -> next cycle all outputs at reset values, no wr_en pulse afterwards, new start completes a full 49-cycle run.
- start pulsed while busy -> ignored, done pulses once only.
- FFT_BITREV_EN defined, identity butterfly, mem[i]=i -> mem = {0,4,2,6,1,5,3,7} and done 6 cycles later than the base case (55 cycles).

Source files
------------

// File: rtl/fft_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fft_mem_ctrl_if
// Desc   : Dual-port RAM and butterfly-datapath bus driven by fft_mem_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
interface fft_mem_ctrl_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 9
);
    logic                 wr_en_0;
    logic                 wr_en_1;
    logic [ADDR_SIZE-1:0] addr_0;
    logic [ADDR_SIZE-1:0] addr_1;
    logic [WIDTH-1:0]     data_0_in;
    logic [WIDTH-1:0]     data_1_in;
    logic [WIDTH-1:0]     data_0_out;
    logic [WIDTH-1:0]     data_1_out;
    logic                 bf_in_valid;
    logic [WIDTH-1:0]     bf_a;
    logic [WIDTH-1:0]     bf_b;
    logic [ADDR_SIZE-2:0] bf_tw_addr;
    logic [WIDTH-1:0]     bf_y0;
    logic [WIDTH-1:0]     bf_y1;

    modport master (
        output wr_en_0, wr_en_1, addr_0, addr_1, data_0_in, data_1_in,
        input  data_0_out, data_1_out,
        output bf_in_valid, bf_a, bf_b, bf_tw_addr,
        input  bf_y0, bf_y1
    );

    modport slave (
        input  wr_en_0, wr_en_1, addr_0, addr_1, data_0_in, data_1_in,
        output data_0_out, data_1_out,
        input  bf_in_valid, bf_a, bf_b, bf_tw_addr,
        output bf_y0, bf_y1
    );
endinterface
`default_nettype wire

// File: rtl/fft_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fft_mem_ctrl
// Desc   : In-place radix-2 DIT FFT sequencer for a dual-port working RAM.
//          Define FFT_BITREV_EN to add an input bit-reversal pass.
// Rev    : 1.0  initial release
// ============================================================================
module fft_mem_ctrl #(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 512,
    parameter int ADDR_SIZE = 9,
    parameter int BF_LAT    = 2
) (
    input  wire            clk,
    input  wire            rst_n,
    input  wire            start,
    output logic           busy,
    output logic           done,
    fft_mem_ctrl_if.master bus
);

    localparam int STAGE_W = $clog2(ADDR_SIZE + 1);
    localparam int K_W     = ADDR_SIZE - 1;
    localparam int CNT_W   = $clog2(BF_LAT + 1);
    localparam logic [K_W-1:0]     K_LAST = K_W'(SIZE / 2 - 1);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(ADDR_SIZE - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RD        = 4'd1,
        ST_WAIT      = 4'd2,
        ST_BF        = 4'd3,
        ST_WR        = 4'd4,
        ST_FIN       = 4'd5
`ifdef FFT_BITREV_EN
        ,
        ST_BREV_RD   = 4'd6,
        ST_BREV_WAIT = 4'd7,
        ST_BREV_WR   = 4'd8
`endif
    } state_t;

    state_t               state;
    logic [STAGE_W-1:0]   r_stage;
    logic [K_W-1:0]       r_k;
    logic [ADDR_SIZE-1:0] r_addr_0;
    logic [ADDR_SIZE-1:0] r_addr_1;
    logic [K_W-1:0]       r_tw;
    logic                 r_wr_en;
    logic                 r_bf_in_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_W-1:0]     r_bf_cnt;

    logic [STAGE_W-1:0]   w_nxt_stage;
    logic [K_W-1:0]       w_nxt_k;
    logic                 w_last;
    logic [ADDR_SIZE-1:0] w_nxt_addr_0;
    logic [ADDR_SIZE-1:0] w_nxt_addr_1;
    logic [K_W-1:0]       w_nxt_tw;

    // addr_0 = (k with bit s opened up as a zero) ; addr_1 sets that bit
    function automatic logic [ADDR_SIZE-1:0] f_addr_0(input logic [STAGE_W-1:0] s,
                                                      input logic [K_W-1:0]     k);
        logic [ADDR_SIZE-1:0] kx;
        logic [ADDR_SIZE-1:0] lo_mask;
        kx      = {1'b0, k};
        lo_mask = (ADDR_SIZE'(1) << s) - ADDR_SIZE'(1);
        return ((kx & ~lo_mask) << 1) | (kx & lo_mask);
    endfunction

    function automatic logic [ADDR_SIZE-1:0] f_addr_1(input logic [STAGE_W-1:0] s,
                                                      input logic [K_W-1:0]     k);
        return f_addr_0(s, k) + (ADDR_SIZE'(1) << s);
    endfunction

    function automatic logic [K_W-1:0] f_tw(input logic [STAGE_W-1:0] s,
                                            input logic [K_W-1:0]     k);
        logic [K_W-1:0]     pos_mask;
        logic [STAGE_W-1:0] sh;
        pos_mask = (K_W'(1) << s) - K_W'(1);
        sh       = S_LAST - s;
        return (k & pos_mask) << sh;
    endfunction

    // Next butterfly coordinates; anything other than WR restarts at (0,0)
    always_comb begin
        w_nxt_stage = '0;
        w_nxt_k     = '0;
        if (state == ST_WR) begin
            if (r_k != K_LAST) begin
                w_nxt_stage = r_stage;
                w_nxt_k     = r_k + 1'b1;
            end else begin
                w_nxt_stage = r_stage + 1'b1;
            end
        end
    end

    assign w_last       = (r_k == K_LAST) && (r_stage == S_LAST);
    assign w_nxt_addr_0 = f_addr_0(w_nxt_stage, w_nxt_k);
    assign w_nxt_addr_1 = f_addr_1(w_nxt_stage, w_nxt_k);
    assign w_nxt_tw     = f_tw(w_nxt_stage, w_nxt_k);

`ifdef FFT_BITREV_EN
    logic [ADDR_SIZE-1:0] r_idx;
    logic [ADDR_SIZE:0]   w_brev_from;
    logic                 w_brev_found;
    logic [ADDR_SIZE-1:0] w_brev_idx;

    function automatic logic [ADDR_SIZE-1:0] f_rev(input logic [ADDR_SIZE-1:0] i);
        logic [ADDR_SIZE-1:0] r;
        for (int b = 0; b < ADDR_SIZE; b++) begin
            r[b] = i[ADDR_SIZE-1-b];
        end
        return r;
    endfunction

    // Smallest index at or after w_brev_from whose reverse is larger, so
    // non-swapping indices cost no cycles
    always_comb begin
        w_brev_from  = (state == ST_IDLE) ? '0 : ({1'b0, r_idx} + 1'b1);
        w_brev_found = 1'b0;
        w_brev_idx   = '0;
        for (int j = SIZE - 1; j >= 0; j--) begin
            if ((j >= int'(w_brev_from)) && (f_rev(ADDR_SIZE'(j)) > ADDR_SIZE'(j))) begin
                w_brev_found = 1'b1;
                w_brev_idx   = ADDR_SIZE'(j);
            end
        end
    end

    assign bus.data_0_in = (state == ST_BREV_WR) ? bus.data_1_out : bus.bf_y0;
    assign bus.data_1_in = (state == ST_BREV_WR) ? bus.data_0_out : bus.bf_y1;
`else
    assign bus.data_0_in = bus.bf_y0;
    assign bus.data_1_in = bus.bf_y1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            r_stage       <= '0;
            r_k           <= '0;
            r_addr_0      <= '0;
            r_addr_1      <= '0;
            r_tw          <= '0;
            r_wr_en       <= 1'b0;
            r_bf_in_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_bf_cnt      <= '0;
`ifdef FFT_BITREV_EN
            r_idx         <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_stage <= w_nxt_stage;
                        r_k     <= w_nxt_k;
`ifdef FFT_BITREV_EN
                        if (w_brev_found) begin
                            r_idx    <= w_brev_idx;
                            r_addr_0 <= w_brev_idx;
                            r_addr_1 <= f_rev(w_brev_idx);
                            state    <= ST_BREV_RD;
                        end else begin
                            r_addr_0 <= w_nxt_addr_0;
                            r_addr_1 <= w_nxt_addr_1;
                            r_tw     <= w_nxt_tw;
                            state    <= ST_RD;
                        end
`else
                        r_addr_0 <= w_nxt_addr_0;
                        r_addr_1 <= w_nxt_addr_1;
                        r_tw     <= w_nxt_tw;
                        state    <= ST_RD;
`endif
                    end
                end
                ST_RD: begin
                    r_bf_in_valid <= 1'b1;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_bf_in_valid <= 1'b0;
                    r_bf_cnt      <= '0;
                    if (BF_LAT == 1) begin
                        r_wr_en <= 1'b1;
                        state   <= ST_WR;
                    end else begin
                        state   <= ST_BF;
                    end
                end
                ST_BF: begin
                    if (r_bf_cnt == CNT_W'(BF_LAT - 2)) begin
                        r_wr_en <= 1'b1;
                        state   <= ST_WR;
                    end else begin
                        r_bf_cnt <= r_bf_cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    r_wr_en <= 1'b0;
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        r_stage  <= w_nxt_stage;
                        r_k      <= w_nxt_k;
                        r_addr_0 <= w_nxt_addr_0;
                        r_addr_1 <= w_nxt_addr_1;
                        r_tw     <= w_nxt_tw;
                        state    <= ST_RD;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
`ifdef FFT_BITREV_EN
                ST_BREV_RD: begin
                    state <= ST_BREV_WAIT;
                end
                ST_BREV_WAIT: begin
                    r_wr_en <= 1'b1;
                    state   <= ST_BREV_WR;
                end
                ST_BREV_WR: begin
                    r_wr_en <= 1'b0;
                    if (w_brev_found) begin
                        r_idx    <= w_brev_idx;
                        r_addr_0 <= w_brev_idx;
                        r_addr_1 <= f_rev(w_brev_idx);
                        state    <= ST_BREV_RD;
                    end else begin
                        r_stage  <= w_nxt_stage;
                        r_k      <= w_nxt_k;
                        r_addr_0 <= w_nxt_addr_0;
                        r_addr_1 <= w_nxt_addr_1;
                        r_tw     <= w_nxt_tw;
                        state    <= ST_RD;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign bus.wr_en_0     = r_wr_en;
    assign bus.wr_en_1     = r_wr_en;
    assign bus.addr_0      = r_addr_0;
    assign bus.addr_1      = r_addr_1;
    assign bus.bf_in_valid = r_bf_in_valid;
    assign bus.bf_a        = bus.data_0_out;
    assign bus.bf_b        = bus.data_1_out;
    assign bus.bf_tw_addr  = r_tw;

endmodule
`default_nettype wire

// File: tb/tb_fft_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_mem_ctrl
// Desc   : Self-checking bench for fft_mem_ctrl with RAM/butterfly models and
//          a reference FFT sequencer model (honours FFT_BITREV_EN).
// Rev    : 1.0  initial release
// ============================================================================
module tb_fft_mem_ctrl;

    localparam int WIDTH     = 32;
    localparam int SIZE      = 8;
    localparam int ADDR_SIZE = 3;
    localparam int BF_LAT    = 2;
    localparam int TW_W      = ADDR_SIZE - 1;
`ifdef FFT_BITREV_EN
    localparam bit BREV = 1'b1;
`else
    localparam bit BREV = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_SIZE-1:0] a0;
        logic [ADDR_SIZE-1:0] a1;
        logic [TW_W-1:0]      tw;
        logic                 chk_tw;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    fft_mem_ctrl_if #(.WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE)) bus ();

    fft_mem_ctrl #(
        .WIDTH(WIDTH), .SIZE(SIZE), .ADDR_SIZE(ADDR_SIZE), .BF_LAT(BF_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem      [SIZE];
    logic [WIDTH-1:0] ram_init [SIZE];
    logic [WIDTH-1:0] exp_mem  [SIZE];
    logic             ram_load = 1'b0;
    int               bf_mode  = 0;
    logic [WIDTH-1:0] yp0 [BF_LAT];
    logic [WIDTH-1:0] yp1 [BF_LAT];
    ent_t             trace [$];
    ent_t             exp_q [$];
    int               exp_pairs;
    int               wr_cnt   = 0;
    int               done_cnt = 0;
    int               viol     = 0;
    int               n_vec    = 0;
    int               n_err    = 0;

    function automatic logic [WIDTH-1:0] bf0(input int m, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic [TW_W-1:0] tw);
        return (m == 0) ? a : a + b + (WIDTH'(tw) & {WIDTH{1'b0}});
    endfunction

    function automatic logic [WIDTH-1:0] bf1(input int m, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic [TW_W-1:0] tw);
        if (m == 0) return b;
        if (m == 1) return a - b;
        return a - b + WIDTH'(tw) * 7 + 1;
    endfunction

    function automatic ent_t mk_ent(input int a0, input int a1, input int tw, input bit c);
        ent_t e;
        e.a0     = ADDR_SIZE'(a0);
        e.a1     = ADDR_SIZE'(a1);
        e.tw     = TW_W'(tw);
        e.chk_tw = c;
        return e;
    endfunction

    function automatic int rev(input int i);
        int r = 0;
        for (int b = 0; b < ADDR_SIZE; b++) begin
            if (((i >> b) & 1) != 0) r = r | (1 << (ADDR_SIZE - 1 - b));
        end
        return r;
    endfunction

    // Read-first synchronous dual-port RAM
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < SIZE; i++) mem[i] <= ram_init[i];
        end else begin
            if (bus.wr_en_0) mem[bus.addr_0] <= bus.data_0_in;
            if (bus.wr_en_1) mem[bus.addr_1] <= bus.data_1_in;
        end
        bus.data_0_out <= mem[bus.addr_0];
        bus.data_1_out <= mem[bus.addr_1];
    end

    // Butterfly with BF_LAT-cycle latency
    always @(posedge clk) begin
        yp0[0] <= bf0(bf_mode, bus.bf_a, bus.bf_b, bus.bf_tw_addr);
        yp1[0] <= bf1(bf_mode, bus.bf_a, bus.bf_b, bus.bf_tw_addr);
        for (int i = 1; i < BF_LAT; i++) begin
            yp0[i] <= yp0[i-1];
            yp1[i] <= yp1[i-1];
        end
    end
    assign bus.bf_y0 = yp0[BF_LAT-1];
    assign bus.bf_y1 = yp1[BF_LAT-1];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en_0 || bus.wr_en_1) begin
                wr_cnt <= wr_cnt + 1;
                trace.push_back(mk_ent(int'(bus.addr_0), int'(bus.addr_1), int'(bus.bf_tw_addr), 1'b0));
            end
            if ((bus.wr_en_0 !== bus.wr_en_1) || (busy && (bus.addr_0 == bus.addr_1)))
                viol <= viol + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: straightforward nested-loop in-place FFT over the RAM image
    task automatic build_model();
        logic [WIDTH-1:0] m [SIZE];
        logic [WIDTH-1:0] a, b, t;
        int span, pos, a0, a1, tw, r;
        for (int i = 0; i < SIZE; i++) m[i] = ram_init[i];
        exp_q.delete();
        exp_pairs = 0;
        if (BREV) begin
            for (int i = 0; i < SIZE; i++) begin
                r = rev(i);
                if (r > i) begin
                    t = m[i]; m[i] = m[r]; m[r] = t;
                    exp_q.push_back(mk_ent(i, r, 0, 1'b0));
                    exp_pairs++;
                end
            end
        end
        for (int s = 0; s < ADDR_SIZE; s++) begin
            span = 1 << s;
            for (int k = 0; k < SIZE / 2; k++) begin
                pos = k % span;
                a0  = (k / span) * 2 * span + pos;
                a1  = a0 + span;
                tw  = pos * ((SIZE / 2) / span);
                a   = m[a0];
                b   = m[a1];
                m[a0] = bf0(bf_mode, a, b, TW_W'(tw));
                m[a1] = bf1(bf_mode, a, b, TW_W'(tw));
                exp_q.push_back(mk_ent(a0, a1, tw, 1'b1));
            end
        end
        for (int i = 0; i < SIZE; i++) exp_mem[i] = m[i];
    endtask

    task automatic load_ram();
        @(negedge clk);
        ram_load = 1'b1;
        @(negedge clk);
        ram_load = 1'b0;
    endtask

    task automatic run_fft(input string tag, input bit extra_start);
        int   cyc, d0, t0, exp_cyc;
        ent_t e;
        build_model();
        exp_cyc = 1 + (SIZE / 2) * ADDR_SIZE * (BF_LAT + 2) + 3 * exp_pairs;
        load_ram();
        d0    = done_cnt;
        t0    = trace.size();
        start = 1'b1;
        cyc   = 0;
        while (cyc < 1000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (extra_start && cyc == 10) start = 1'b1;
            if (cyc == 1) chk({tag, ".busy_rise"}, 64'(busy), 64'd1);
            if (done) break;
        end
        chk({tag, ".cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".done_width"}, 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk({tag, ".start_at_done_ignored"}, 64'(busy), 64'd0);
        chk({tag, ".done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, ".writes"}, 64'(trace.size() - t0), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (t0 + i < trace.size()) begin
                e = trace[t0 + i];
                chk($sformatf("%s.addr_0[%0d]", tag, i), 64'(e.a0), 64'(exp_q[i].a0));
                chk($sformatf("%s.addr_1[%0d]", tag, i), 64'(e.a1), 64'(exp_q[i].a1));
                if (exp_q[i].chk_tw)
                    chk($sformatf("%s.tw[%0d]", tag, i), 64'(e.tw), 64'(exp_q[i].tw));
            end
        end
        for (int i = 0; i < SIZE; i++)
            chk($sformatf("%s.mem[%0d]", tag, i), 64'(mem[i]), 64'(exp_mem[i]));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".busy"},        64'(busy),            64'd0);
        chk({tag, ".done"},        64'(done),            64'd0);
        chk({tag, ".wr_en_0"},     64'(bus.wr_en_0),     64'd0);
        chk({tag, ".wr_en_1"},     64'(bus.wr_en_1),     64'd0);
        chk({tag, ".addr_0"},      64'(bus.addr_0),      64'd0);
        chk({tag, ".addr_1"},      64'(bus.addr_1),      64'd0);
        chk({tag, ".bf_in_valid"}, 64'(bus.bf_in_valid), 64'd0);
        chk({tag, ".bf_tw_addr"},  64'(bus.bf_tw_addr),  64'd0);
    endtask

    initial begin
        int w0, v0;
        v0 = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        v0 = viol;

        // Identity butterfly over a ramp: RAM unchanged (or bit-reversed)
        bf_mode = 0;
        for (int i = 0; i < SIZE; i++) ram_init[i] = WIDTH'(i);
        run_fft("ident", 1'b0);

        // Impulse through sum/difference butterflies spreads to all ones
        bf_mode = 1;
        for (int i = 0; i < SIZE; i++) ram_init[i] = (i == 0) ? 32'd1 : 32'd0;
        run_fft("impulse", 1'b0);
        for (int i = 0; i < SIZE; i++)
            chk($sformatf("impulse.ones[%0d]", i), 64'(mem[i]), 64'd1);

        // Random data and butterfly flavours; iteration 1 pulses start while busy
        for (int it = 0; it < 3; it++) begin
            bf_mode = int'($urandom_range(0, 2));
            for (int i = 0; i < SIZE; i++) ram_init[i] = $urandom;
            run_fft($sformatf("rand%0d", it), it == 1);
        end

        // Reset in the middle of stage 1
        bf_mode = 2;
        for (int i = 0; i < SIZE; i++) ram_init[i] = $urandom;
        load_ram();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        w0 = wr_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midreset.no_writes", 64'(wr_cnt - w0), 64'd0);
        chk("midreset.idle", 64'(busy), 64'd0);
        for (int i = 0; i < SIZE; i++) ram_init[i] = $urandom;
        run_fft("after_reset", 1'b0);

        chk("port_invariants", 64'(viol - v0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
